// File: rtl/fpu_issue_pkg.sv
// ----------------------------------------------------------------------------
// fpu_issue_pkg : shared op codes, widths and response entry for fpu_issue_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fpu_issue_pkg;

  localparam int FPU_LATENCY_DEFAULT = 2;
  localparam int TAG_W_DEFAULT       = 4;
  localparam int DATA_W              = 32;

  typedef enum logic [0:0] {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } fpu_op_e;

  // Default-width entry; modules with a non-default TAG_W declare the same
  // layout locally at their own width.
  typedef struct packed {
    logic [TAG_W_DEFAULT-1:0] tag;
    logic [DATA_W-1:0]        result;
  } rsp_entry_t;

  function automatic int rsp_entry_width(input int tag_w);
    return tag_w + DATA_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_rsp_fifo.sv
// ----------------------------------------------------------------------------
// fpu_rsp_fifo : synchronous show-ahead FIFO with wrap-bit full/empty detection
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign o_empty    = (wr_ptr_q == rd_ptr_q);
  assign o_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_count    = wr_ptr_q - rd_ptr_q;
  assign o_pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_push && !o_full) wr_ptr_d = wr_ptr_q + 1'b1;
    if (i_pop && !o_empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
  end

  a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_pop && o_empty));

endmodule

`default_nettype wire

// File: rtl/fpu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// fpu_issue_ctrl : credit-based request/response front end for FPU_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int NUM_OP      = 1,
  parameter int FPU_LATENCY = FPU_LATENCY_DEFAULT,
  parameter int RSP_DEPTH   = 4,
  parameter int TAG_W       = TAG_W_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [NUM_OP-1:0]             i_req_op,
  input  logic [31:0]                   i_req_a,
  input  logic [31:0]                   i_req_b,
  input  logic [TAG_W-1:0]              i_req_tag,
  output logic [NUM_OP-1:0]             o_fpu_op,
  output logic [31:0]                   o_fpu_a,
  output logic [31:0]                   o_fpu_b,
  input  logic [31:0]                   i_fpu_result,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic [31:0]                   o_rsp_result,
  output logic [TAG_W-1:0]              o_rsp_tag,
  output logic [$clog2(RSP_DEPTH):0]    o_inflight,
  output logic                          o_busy
);

  localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
  localparam int STAGES = FPU_LATENCY + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] result;
  } rsp_t;

  logic                         accept;
  logic                         pop;
  logic [CNT_W-1:0]             credit_q, credit_d;
  logic [NUM_OP-1:0]            op_q;
  logic [31:0]                  a_q, b_q;
  logic [STAGES-1:0]            stg_vld_q;
  logic [STAGES-1:0][TAG_W-1:0] stg_tag_q;
  rsp_t                         push_entry, pop_entry;
  logic [$bits(rsp_t)-1:0]      fifo_rdata;
  logic                         fifo_full, fifo_empty;
  logic [CNT_W-1:0]             fifo_count;

  // Ready comes from the registered count, so a pop frees its credit one cycle later.
  assign o_req_ready = i_rst_n && (credit_q < CNT_W'(RSP_DEPTH));
  assign accept      = i_req_valid && o_req_ready;
  assign pop         = !fifo_empty && i_rsp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= i_req_op;
      a_q  <= i_req_a;
      b_q  <= i_req_b;
    end
  end

  assign o_fpu_op = op_q;
  assign o_fpu_a  = a_q;
  assign o_fpu_b  = b_q;

  // Stage STAGES-1 lines up with i_fpu_result for the operation it tags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stg_vld_q <= '0;
      stg_tag_q <= '0;
    end else begin
      stg_vld_q <= {stg_vld_q[STAGES-2:0], accept};
      stg_tag_q <= {stg_tag_q[STAGES-2:0], i_req_tag};
    end
  end

  always_comb begin
    credit_d = credit_q;
    case ({accept, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) credit_q <= '0;
    else          credit_q <= credit_d;
  end

  assign push_entry = '{tag: stg_tag_q[STAGES-1], result: i_fpu_result};

  fpu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH ($bits(rsp_t))
  ) u_rsp_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (stg_vld_q[STAGES-1]),
    .i_push_data (push_entry),
    .i_pop       (pop),
    .o_pop_data  (fifo_rdata),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  assign pop_entry    = rsp_t'(fifo_rdata);
  assign o_rsp_valid  = !fifo_empty;
  assign o_rsp_result = fifo_empty ? '0 : pop_entry.result;
  assign o_rsp_tag    = fifo_empty ? '0 : pop_entry.tag;
  assign o_inflight   = credit_q;
  assign o_busy       = (credit_q != '0);

  a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(stg_vld_q[STAGES-1] && fifo_full));

  a_credit_covers_fifo : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    fifo_count <= credit_q);

endmodule

`default_nettype wire
